// File: rtl/lspc_timer_irq_if.sv
// rtl/lspc_timer_irq_if.sv - CPU register write bus into the LSPC timer/IRQ block
interface lspc_timer_irq_if;
  logic [15:0] CPU_D;
  logic        WR_TIMER_HIGH;
  logic        WR_TIMER_LOW;
  logic        WR_MODE;
  logic        WR_ACK;

  modport master (
    output CPU_D, WR_TIMER_HIGH, WR_TIMER_LOW, WR_MODE, WR_ACK
  );

  modport slave (
    input CPU_D, WR_TIMER_HIGH, WR_TIMER_LOW, WR_MODE, WR_ACK
  );
endinterface

// File: rtl/lspc_timer_irq.sv
// rtl/lspc_timer_irq.sv - LSPC pixel-rate timer, vblank and reset interrupt generator
module lspc_timer_irq #(
  parameter logic [31:0] RELOAD_AT_RESET = 32'h0000_0000
) (
  input  logic                  CLK_24MB,
  input  logic                  nRESETP,
  input  logic                  PIX_EN,
  input  logic                  VMODE,
  input  logic [8:0]            RASTERC,
  input  logic                  BNK,
  lspc_timer_irq_if.slave       bus,
  output logic                  IRQ_VBL,
  output logic                  IRQ_TIMER,
  output logic                  IRQ_RESET,
  output logic [31:0]           TIMER_Q
);

  logic [31:0] reload;
  logic [8:4]  mode;
  logic        bnk_q;

  logic [7:0]  line;
  logic        stop;
  logic        step;
  logic        zero_evt;
  logic        vbs;
  logic        low_load;
  logic [15:0] reload_hi_next;

  assign line = RASTERC[8:1];

  // First and last 16 PAL lines freeze the counter when M8 is set.
  assign stop = VMODE & mode[8] &
                (((line >= 8'h64) && (line <= 8'h6B)) || (line >= 8'hF8));

  assign step     = PIX_EN & ~stop;
  assign zero_evt = step & (TIMER_Q == 32'h0000_0000);
  assign vbs      = bnk_q & ~BNK;
  assign low_load = bus.WR_TIMER_LOW & mode[5];

  // A high word written on the same edge as the low word is taken as well.
  assign reload_hi_next = bus.WR_TIMER_HIGH ? bus.CPU_D : reload[31:16];

  always_ff @(posedge CLK_24MB or negedge nRESETP) begin
    if (!nRESETP) begin
      TIMER_Q   <= RELOAD_AT_RESET;
      reload    <= RELOAD_AT_RESET;
      mode      <= '0;
      bnk_q     <= 1'b1;
      IRQ_VBL   <= 1'b0;
      IRQ_TIMER <= 1'b0;
      IRQ_RESET <= 1'b1;
    end else begin
      bnk_q <= BNK;

      if (bus.WR_TIMER_HIGH) reload[31:16] <= bus.CPU_D;
      if (bus.WR_TIMER_LOW)  reload[15:0]  <= bus.CPU_D;
      if (bus.WR_MODE)       mode          <= bus.CPU_D[8:4];

      if (low_load)
        TIMER_Q <= {reload_hi_next, bus.CPU_D};
      else if (zero_evt)
        TIMER_Q <= mode[7] ? reload : 32'hFFFF_FFFF;
      else if (vbs && mode[6])
        TIMER_Q <= reload;
      else if (step)
        TIMER_Q <= TIMER_Q - 32'd1;

      // Set beats a same-cycle acknowledge.
      if (zero_evt && mode[4])
        IRQ_TIMER <= 1'b1;
      else if (bus.WR_ACK && bus.CPU_D[1])
        IRQ_TIMER <= 1'b0;

      if (vbs)
        IRQ_VBL <= 1'b1;
      else if (bus.WR_ACK && bus.CPU_D[2])
        IRQ_VBL <= 1'b0;

      if (bus.WR_ACK && bus.CPU_D[0])
        IRQ_RESET <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lspc_timer_irq.sv
// tb/tb_lspc_timer_irq.sv - self-checking bench for lspc_timer_irq
module tb_lspc_timer_irq;

  logic        CLK_24MB = 1'b0;
  logic        nRESETP;
  logic        PIX_EN;
  logic        VMODE;
  logic [8:0]  RASTERC;
  logic        BNK;
  logic        IRQ_VBL, IRQ_TIMER, IRQ_RESET;
  logic [31:0] TIMER_Q;

  lspc_timer_irq_if bus ();

  lspc_timer_irq dut (
    .CLK_24MB  (CLK_24MB),
    .nRESETP   (nRESETP),
    .PIX_EN    (PIX_EN),
    .VMODE     (VMODE),
    .RASTERC   (RASTERC),
    .BNK       (BNK),
    .bus       (bus),
    .IRQ_VBL   (IRQ_VBL),
    .IRQ_TIMER (IRQ_TIMER),
    .IRQ_RESET (IRQ_RESET),
    .TIMER_Q   (TIMER_Q)
  );

  always #5 CLK_24MB = ~CLK_24MB;

  int checks = 0;
  int fails  = 0;

  // Reference state, kept as plain values rather than RTL registers.
  logic [31:0] m_cnt, m_reload;
  logic [15:0] m_mode;
  logic        m_vbl, m_tmr, m_rst, m_bnk_prev;

  task automatic model_reset();
    m_cnt = 0; m_reload = 0; m_mode = 0;
    m_vbl = 0; m_tmr = 0; m_rst = 1; m_bnk_prev = 1;
  endtask

  task automatic model_edge();
    logic [7:0]  ln;
    logic [15:0] hi;
    bit          stop, zero, vbs;
    ln   = RASTERC[8:1];
    stop = VMODE && m_mode[8] && ((ln >= 8'h64 && ln <= 8'h6B) || ln >= 8'hF8);
    zero = PIX_EN && !stop && (m_cnt == 0);
    vbs  = m_bnk_prev && !BNK;
    hi   = bus.WR_TIMER_HIGH ? bus.CPU_D : m_reload[31:16];
    if (bus.WR_TIMER_LOW && m_mode[5]) m_cnt = {hi, bus.CPU_D};
    else if (zero)                     m_cnt = m_mode[7] ? m_reload : 32'hFFFF_FFFF;
    else if (vbs && m_mode[6])         m_cnt = m_reload;
    else if (PIX_EN && !stop)          m_cnt = m_cnt - 1;
    if (zero && m_mode[4])                   m_tmr = 1;
    else if (bus.WR_ACK && bus.CPU_D[1])     m_tmr = 0;
    if (vbs)                                 m_vbl = 1;
    else if (bus.WR_ACK && bus.CPU_D[2])     m_vbl = 0;
    if (bus.WR_ACK && bus.CPU_D[0])          m_rst = 0;
    m_reload = {hi, bus.WR_TIMER_LOW ? bus.CPU_D : m_reload[15:0]};
    if (bus.WR_MODE) m_mode = bus.CPU_D & 16'h01F0;
    m_bnk_prev = BNK;
  endtask

  // One clock: inputs already driven, model follows the edge, strobes cleared after.
  task automatic tick(input bit pix);
    PIX_EN = pix;
    @(posedge CLK_24MB);
    model_edge();
    #1;
    PIX_EN = 0;
    bus.WR_TIMER_HIGH = 0; bus.WR_TIMER_LOW = 0;
    bus.WR_MODE = 0; bus.WR_ACK = 0; bus.CPU_D = 0;
  endtask

  task automatic wr_mode(input logic [15:0] d);
    bus.CPU_D = d; bus.WR_MODE = 1; tick(0);
  endtask
  task automatic wr_high(input logic [15:0] d);
    bus.CPU_D = d; bus.WR_TIMER_HIGH = 1; tick(0);
  endtask
  task automatic wr_low(input logic [15:0] d);
    bus.CPU_D = d; bus.WR_TIMER_LOW = 1; tick(0);
  endtask
  task automatic wr_ack(input logic [15:0] d);
    bus.CPU_D = d; bus.WR_ACK = 1; tick(0);
  endtask

  // Three idle clocks then a PIX_EN clock, like the real 6 MHz strobe.
  task automatic pix4();
    tick(0); tick(0); tick(0); tick(1);
  endtask

  task automatic test_reset();
    nRESETP = 0; PIX_EN = 0; VMODE = 0; RASTERC = 0; BNK = 1;
    bus.CPU_D = 0; bus.WR_TIMER_HIGH = 0; bus.WR_TIMER_LOW = 0;
    bus.WR_MODE = 0; bus.WR_ACK = 0;
    model_reset();
    repeat (3) @(posedge CLK_24MB);
    #1 nRESETP = 1;
    tick(0);
    checks++;
    if ({IRQ_RESET, IRQ_TIMER, IRQ_VBL} !== 3'b100) begin
      fails++; $display("FAIL reset_irqs got=%b want=100", {IRQ_RESET, IRQ_TIMER, IRQ_VBL});
    end
    checks++;
    if (TIMER_Q !== 32'h0) begin
      fails++; $display("FAIL reset_timer got=%h want=00000000", TIMER_Q);
    end
    wr_ack(16'h0001);
    checks++;
    if (IRQ_RESET !== 1'b0) begin
      fails++; $display("FAIL reset_ack got=%b want=0", IRQ_RESET);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] want [4] = '{32'd2, 32'd1, 32'd0, 32'd3};
    wr_mode(16'h00B0);
    wr_high(16'h0000);
    wr_low(16'h0003);
    checks++;
    if (TIMER_Q !== 32'd3) begin
      fails++; $display("FAIL periodic_load got=%h want=00000003", TIMER_Q);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        pix4();
        checks++;
        if (TIMER_Q !== want[i]) begin
          fails++; $display("FAIL periodic_count r=%0d i=%0d got=%h want=%h", r, i, TIMER_Q, want[i]);
        end
      end
      checks++;
      if (IRQ_TIMER !== 1'b1) begin
        fails++; $display("FAIL periodic_irq r=%0d got=%b want=1", r, IRQ_TIMER);
      end
      wr_ack(16'h0002);
      checks++;
      if (IRQ_TIMER !== 1'b0) begin
        fails++; $display("FAIL periodic_ack r=%0d got=%b want=0", r, IRQ_TIMER);
      end
    end
  endtask

  task automatic test_wrap_ack();
    wr_mode(16'h0010);
    repeat (4) pix4();
    checks++;
    if (IRQ_TIMER !== 1'b1 || TIMER_Q !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL wrap_irq got=%b/%h want=1/ffffffff", IRQ_TIMER, TIMER_Q);
    end
    wr_mode(16'h0030);
    wr_low(16'h0000);
    wr_mode(16'h0010);
    bus.CPU_D = 16'h0002; bus.WR_ACK = 1;
    tick(1);
    checks++;
    if (IRQ_TIMER !== 1'b1 || TIMER_Q !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL set_beats_ack got=%b/%h want=1/ffffffff", IRQ_TIMER, TIMER_Q);
    end
    wr_ack(16'h0002);
    checks++;
    if (IRQ_TIMER !== 1'b0) begin
      fails++; $display("FAIL wrap_ack got=%b want=0", IRQ_TIMER);
    end
  endtask

  task automatic test_vblank();
    wr_mode(16'h0040);
    wr_high(16'h1234);
    wr_low(16'h5678);
    BNK = 0;
    tick(0);
    checks++;
    if (IRQ_VBL !== 1'b1 || TIMER_Q !== 32'h1234_5678) begin
      fails++; $display("FAIL vbs_load got=%b/%h want=1/12345678", IRQ_VBL, TIMER_Q);
    end
    wr_ack(16'h0004);
    repeat (5) tick(0);
    checks++;
    if (IRQ_VBL !== 1'b0) begin
      fails++; $display("FAIL vbs_held_low got=%b want=0", IRQ_VBL);
    end
    BNK = 1;
    tick(0);
  endtask

  task automatic test_stop();
    logic [31:0] start;
    start = m_cnt;
    wr_mode(16'h0100);
    VMODE = 1; RASTERC = {8'h66, 1'b0};
    repeat (10) pix4();
    checks++;
    if (TIMER_Q !== start) begin
      fails++; $display("FAIL pal_stop got=%h want=%h", TIMER_Q, start);
    end
    RASTERC = {8'h6C, 1'b1};
    pix4();
    checks++;
    if (TIMER_Q !== start - 32'd1) begin
      fails++; $display("FAIL pal_run got=%h want=%h", TIMER_Q, start - 32'd1);
    end
    VMODE = 0; RASTERC = {8'h66, 1'b0};
    repeat (10) pix4();
    checks++;
    if (TIMER_Q !== start - 32'd11) begin
      fails++; $display("FAIL ntsc_run got=%h want=%h", TIMER_Q, start - 32'd11);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 1500; i++) begin
      VMODE   = 1'($urandom_range(0, 1));
      RASTERC = 9'($urandom);
      if ($urandom_range(0, 15) == 0) BNK = ~BNK;
      bus.CPU_D = 16'($urandom);
      case ($urandom_range(0, 11))
        0: bus.WR_TIMER_HIGH = 1;
        1: begin bus.WR_TIMER_LOW = 1; bus.CPU_D = 16'($urandom_range(0, 12)); end
        2: bus.WR_MODE = 1;
        3: bus.WR_ACK = 1;
        4: begin bus.WR_TIMER_HIGH = 1; bus.WR_TIMER_LOW = 1; end
        default: ;
      endcase
      tick((i % 4) == 3);
      checks++;
      if ({IRQ_VBL, IRQ_TIMER, IRQ_RESET} !== {m_vbl, m_tmr, m_rst} || TIMER_Q !== m_cnt) begin
        fails++;
        if (errs++ < 10)
          $display("FAIL random cyc=%0d got=%b%b%b/%h want=%b%b%b/%h", i,
                   IRQ_VBL, IRQ_TIMER, IRQ_RESET, TIMER_Q, m_vbl, m_tmr, m_rst, m_cnt);
      end
    end
    BNK = 1; VMODE = 0; tick(0);
  endtask

  task automatic test_async_reset();
    wr_mode(16'h0030);
    wr_high(16'h0000);
    wr_low(16'h0000);
    tick(1);
    wr_low(16'h0100);
    checks++;
    if (TIMER_Q !== 32'h100 || IRQ_TIMER !== 1'b1) begin
      fails++; $display("FAIL async_setup got=%h/%b want=00000100/1", TIMER_Q, IRQ_TIMER);
    end
    #2 nRESETP = 0;
    #1;
    model_reset();
    checks++;
    if (TIMER_Q !== 32'h0 || {IRQ_RESET, IRQ_TIMER, IRQ_VBL} !== 3'b100) begin
      fails++; $display("FAIL async_reset got=%h/%b want=00000000/100", TIMER_Q, {IRQ_RESET, IRQ_TIMER, IRQ_VBL});
    end
    @(posedge CLK_24MB);
    #1 nRESETP = 1;
    tick(1);
    checks++;
    if (TIMER_Q !== 32'hFFFF_FFFF || IRQ_TIMER !== 1'b0) begin
      fails++; $display("FAIL async_mode_cleared got=%h/%b want=ffffffff/0", TIMER_Q, IRQ_TIMER);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_wrap_ack();
    test_vblank();
    test_stop();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/lspc_timer_irq.md
Name: lspc_timer_irq

Overview:
- Downstream consumer of the video sync stage: takes its raster counter and blanking outputs, together with CPU register writes, and generates the three LSPC interrupt request lines.
- Implements the 32-bit pixel-rate programmable timer, the vertical-blank IRQ and the power-on/reset IRQ.
- Sits between the LSPC sync logic and the 68k interrupt encoder.

Parameters:
- RELOAD_AT_RESET, 32'h0000_0000, value loaded into the counter and the reload register on reset.

Ports:
- CLK_24MB  in  1  master 24 MHz clock; all state changes on its rising edge.
- nRESETP  in  1  reset: asynchronous, active-low.
- PIX_EN  in  1  one-cycle strobe at 6 MHz (every 4th CLK_24MB); the counter advances only on this strobe.
- VMODE  in  1  1 = PAL, 0 = NTSC.
- RASTERC  in  9  raster counter from sync stage; line code = RASTERC[8:1].
- BNK  in  1  blanking from sync stage, active-low (0 = blanked).
- CPU_D  in  16  CPU write data.
- WR_TIMER_HIGH  in  1  one-cycle write strobe, timer reload high word.
- WR_TIMER_LOW  in  1  one-cycle write strobe, timer reload low word.
- WR_MODE  in  1  one-cycle write strobe, mode register (CPU_D[8:4]).
- WR_ACK  in  1  one-cycle write strobe, IRQ acknowledge (CPU_D[2:0]).
- IRQ_VBL  out  1  level-1 request (vblank), active-high.
- IRQ_TIMER  out  1  level-2 request (timer), active-high.
- IRQ_RESET  out  1  level-3 request (reset), active-high.
- TIMER_Q  out  32  current counter value, for debug and the bench.

Behaviour:
Reset (nRESETP=0, asynchronous):
- counter = RELOAD_AT_RESET, reload register = RELOAD_AT_RESET, mode = 0.
- IRQ_VBL = 0, IRQ_TIMER = 0, IRQ_RESET = 1.
- BNK edge detector = 1.
- A reset asserted mid-count aborts the count immediately; nothing is retained.

Mode bits (latched from CPU_D on WR_MODE):
- M4: timer IRQ enable.
- M5: reload on low-word write.
- M6: reload at vblank start.
- M7: reload at zero.
- M8: PAL timer stop.

Register writes:
- WR_TIMER_HIGH: reload[31:16] <= CPU_D.
- WR_TIMER_LOW: reload[15:0] <= CPU_D. If M5=1, the counter is also loaded with {reload[31:16], CPU_D} on the same edge. This includes a high word written in the immediately preceding cycle.

Vblank start:
- Event VBS = BNK previous-sample 1 and current sample 0. BNK is registered once per CLK_24MB.
- VBS sets IRQ_VBL = 1.
- If M6=1, VBS also loads the counter from reload. This load does not depend on PIX_EN.

Stop window:
- STOP = VMODE & M8 & (line code in 8'h64..8'h6B or 8'hF8..8'hFF), i.e. the first and last 16 PAL lines.
- While STOP=1 the counter holds. Zero events are suppressed; reload loads still apply.
- STOP is ignored in NTSC.

Counter step (on PIX_EN, when not STOP):
- If counter == 0, this is a zero event:
  - if M4=1, IRQ_TIMER is set;
  - the counter then loads reload if M7=1, else wraps to 32'hFFFF_FFFF.
- Otherwise the counter decrements by 1, modulo 2^32.

Counter update priority in one cycle, highest first:
1. Low-write reload (M5).
2. Zero-event action.
3. VBS reload (M6).
4. Decrement.
5. Hold.

A zero event coinciding with a low-write reload still sets IRQ_TIMER.

Acknowledge (WR_ACK):
- CPU_D[0] clears IRQ_RESET, CPU_D[1] clears IRQ_TIMER, CPU_D[2] clears IRQ_VBL.
- If a set and an ack for the same flag occur in the same cycle, the set wins and the flag stays 1.

Other rules:
- Clearing M4 does not clear a pending IRQ_TIMER.
- All outputs are registered; IRQ latency is 1 CLK_24MB edge after the triggering event.

Test Plan:
- Reset release -> IRQ_RESET=1, IRQ_TIMER=0, IRQ_VBL=0, TIMER_Q=0. WR_ACK with D=0x0001 -> IRQ_RESET=0 next edge.
- High=0x0000, low=0x0003, mode=0x00B0 (M4, M5, M7) -> TIMER_Q=3 right after the low write. The count runs 2,1,0 on successive PIX_EN. The 4th PIX_EN sets IRQ_TIMER and reloads 3; the cycle repeats every 4 PIX_EN.
- Mode=0x0010 (M4 only), counter reaches 0 -> IRQ_TIMER=1 and TIMER_Q=0xFFFFFFFF. Ack D=0x0002 in the same cycle as a second zero event -> IRQ_TIMER stays 1.
- BNK 1->0 with mode=0x0040 (M6), reload=0x12345678 -> IRQ_VBL=1 and TIMER_Q=0x12345678 one edge later, even without PIX_EN. BNK held 0 -> no second event.
- VMODE=1, mode=0x0100 (M8), RASTERC[8:1]=0x66 -> TIMER_Q is unchanged across 10 PIX_EN. At line code 0x6C it decrements. Repeat with VMODE=0 -> it decrements throughout.
- nRESETP pulsed low mid-count at TIMER_Q=0x00000100 with IRQ_TIMER=1 -> all registers return to reset values immediately, without waiting for a clock edge.
